// File: rtl/sid_dac_sched.sv
`default_nettype none
// ============================================================================
//  Module   : sid_dac_sched
//  Purpose  : Time-multiplexed R-2R DAC conversion engine. Up to NREQ
//             requesters share one bit-serial weighted-sum accumulator that
//             evaluates one DAC bit per clock. Requesters are served
//             round-robin. Each grant uses either the MOS 6581 non-linear
//             bit-weight table or the ideal MOS 8580 binary weights.
//  Ports    :
//     clk       in   system clock, all state on rising edge
//     rst_n     in   asynchronous active-low reset
//     req       in   [NREQ]      per-requester level request, held until ack
//     req_code  in   [NREQ*12]   requester k code at [12k+11:12k]
//     req_8580  in   [NREQ]      1 = 8580 ideal weights, 0 = 6581 table
//     ack       out  [NREQ]      one-hot 1-cycle delivery pulse
//     dout      out  [12]        converted value, held until next delivery
//     dout_id   out  [IDW]       requester index of dout
//     busy      out              high while converting (ACCUM/DONE)
//  Revision : 1.0  initial release
// ============================================================================
module sid_dac_sched #(
   parameter  int NREQ = 4,
   localparam int IDW  = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*12-1:0]   req_code,
   input  logic [NREQ-1:0]      req_8580,
   output logic [NREQ-1:0]      ack,
   output logic [11:0]          dout,
   output logic [IDW-1:0]       dout_id,
   output logic                 busy
);

   localparam logic [1:0]  c_IDLE       = 2'd0;
   localparam logic [1:0]  c_ACCUM      = 2'd1;
   localparam logic [1:0]  c_DONE       = 2'd2;
   // 0.5 LSB in the 4-bit fractional scale, so truncation rounds to nearest
   localparam logic [15:0] c_ACC_PRESET = 16'h0008;
   localparam logic [3:0]  c_LAST_BIT   = 4'd11;

   logic [1:0]       r_state;
   logic [15:0]      r_acc;
   logic [3:0]       r_bit_idx;
   logic [IDW-1:0]   r_rr_ptr;
   logic [11:0]      r_code;
   logic             r_8580;
   logic [IDW-1:0]   r_id;
   logic [NREQ-1:0]  r_ack;
   logic [11:0]      r_dout;
   logic [IDW-1:0]   r_dout_id;

   logic             w_gnt_vld;
   logic [IDW-1:0]   w_gnt_id;
   logic [IDW-1:0]   w_rr_next;
   logic [11:0]      w_gnt_code;
   logic             w_gnt_8580;
   logic [15:0]      w_weight;
   logic [15:0]      w_acc_next;

   // Bit weights with 4 fractional bits. The 6581 table models the mismatched
   // R-2R ladder of the original die; both tables sum to 0xFFF0.
   function automatic logic [15:0] f_weight(input logic [3:0] idx, input logic m8580);
      logic [15:0] w;
      w = 16'h0000;
      if (m8580) begin
         if (idx <= c_LAST_BIT) w = 16'h0010 << idx;
      end else begin
         case (idx)
            4'd0:    w = 16'h0021;
            4'd1:    w = 16'h0030;
            4'd2:    w = 16'h0055;
            4'd3:    w = 16'h00A0;
            4'd4:    w = 16'h0135;
            4'd5:    w = 16'h0256;
            4'd6:    w = 16'h0486;
            4'd7:    w = 16'h08C6;
            4'd8:    w = 16'h1102;
            4'd9:    w = 16'h20F8;
            4'd10:   w = 16'h3FEC;
            4'd11:   w = 16'h7BED;
            default: w = 16'h0000;
         endcase
      end
      return w;
   endfunction

   // Round-robin pick: scan offsets from the highest down so the last hit,
   // i.e. the one nearest rr_ptr, wins.
   always_comb begin
      w_gnt_vld  = 1'b0;
      w_gnt_id   = '0;
      w_rr_next  = r_rr_ptr;
      w_gnt_code = 12'h000;
      w_gnt_8580 = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[(int'(r_rr_ptr) + i) % NREQ]) begin
            w_gnt_vld  = 1'b1;
            w_gnt_id   = IDW'((int'(r_rr_ptr) + i) % NREQ);
            w_rr_next  = IDW'((int'(r_rr_ptr) + i + 1) % NREQ);
            w_gnt_code = req_code[12*((int'(r_rr_ptr) + i) % NREQ) +: 12];
            w_gnt_8580 = req_8580[(int'(r_rr_ptr) + i) % NREQ];
         end
      end
   end

   // Single shared adder: one weight per cycle. Worst case lands at 0xFFF8,
   // so the 16-bit sum cannot wrap.
   always_comb begin
      w_weight   = r_code[r_bit_idx] ? f_weight(r_bit_idx, r_8580) : 16'h0000;
      w_acc_next = r_acc + w_weight;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_IDLE;
         r_acc     <= 16'h0000;
         r_bit_idx <= 4'd0;
         r_rr_ptr  <= '0;
         r_code    <= 12'h000;
         r_8580    <= 1'b0;
         r_id      <= '0;
         r_ack     <= '0;
         r_dout    <= 12'h000;
         r_dout_id <= '0;
      end else begin
         r_ack <= '0;
         case (r_state)
            c_IDLE: begin
               if (w_gnt_vld) begin
                  r_code    <= w_gnt_code;
                  r_8580    <= w_gnt_8580;
                  r_id      <= w_gnt_id;
                  r_acc     <= c_ACC_PRESET;
                  r_bit_idx <= 4'd0;
                  r_rr_ptr  <= w_rr_next;
                  r_state   <= c_ACCUM;
               end
            end
            c_ACCUM: begin
               r_acc     <= w_acc_next;
               r_bit_idx <= r_bit_idx + 4'd1;
               // Results are registered on the last add so that ack, dout and
               // dout_id are all valid during the DONE cycle.
               if (r_bit_idx == c_LAST_BIT) begin
                  r_state     <= c_DONE;
                  r_ack[r_id] <= 1'b1;
                  r_dout      <= w_acc_next[15:4];
                  r_dout_id   <= r_id;
               end
            end
            c_DONE: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign ack     = r_ack;
   assign dout    = r_dout;
   assign dout_id = r_dout_id;
   assign busy    = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sid_dac_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sid_dac_sched
//  Purpose  : Scoreboard bench for sid_dac_sched. Stimulus pushes the
//             hand-computed expected {id, dout} per conversion; a monitor pops
//             and compares on every ack pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sid_dac_sched;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req;
   logic [NREQ*12-1:0]  req_code;
   logic [NREQ-1:0]     req_8580;
   logic [NREQ-1:0]     ack;
   logic [11:0]         dout;
   logic [IDW-1:0]      dout_id;
   logic                busy;

   typedef struct {
      int id;
      int dout;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   cyc     = 0;
   int   n_total = 0;
   int   n_pass  = 0;

   sid_dac_sched #(.NREQ(NREQ)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_code (req_code),
      .req_8580 (req_8580),
      .ack      (ack),
      .dout     (dout),
      .dout_id  (dout_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
   endtask

   // Monitor: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && (|ack)) begin
         chk("ack_onehot", int'($onehot(ack)), 1);
         if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_ack: got ack=%b expected none", ack);
         end else begin
            mon_e = sb_q.pop_front();
            chk("dout_id", int'(dout_id), mon_e.id);
            chk("ack_bit", int'(ack[mon_e.id]), 1);
            chk("dout",    int'(dout), mon_e.dout);
         end
      end
   end

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
      if (!ok) fail_now("wait_idle");
   endtask

   task automatic wait_ack(output int c);
      bit ok;
      ok = 1'b0;
      c  = -1;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         if (|ack) begin
            ok = 1'b1;
            c  = cyc;
         end
      end
      if (!ok) fail_now("wait_ack");
   endtask

   // One conversion from an idle engine; optionally disturbs the inputs
   // mid-conversion to prove they were captured at grant.
   task automatic convert(input int id, input logic [11:0] code, input logic m,
                          input logic [11:0] exp, input bit mutate);
      int t0;
      bit got;
      wait_idle();
      req_code[12*id +: 12] = code;
      req_8580[id]          = m;
      req[id]               = 1'b1;
      sb_q.push_back('{id, int'(exp)});
      t0  = cyc;
      got = 1'b0;
      for (int n = 1; n <= 40 && !got; n++) begin
         @(negedge clk);
         if (n == 1) chk("busy_accum", int'(busy), 1);
         if (mutate && n == 4) begin
            req_code[12*id +: 12] = ~code;
            req_8580[id]          = ~m;
         end
         if (|ack) begin
            got = 1'b1;
            chk("latency", cyc - t0, 13);
         end
      end
      if (!got) fail_now("convert_ack");
      req[id] = 1'b0;
      repeat (2) @(negedge clk);
      chk("dout_hold", int'(dout), int'(exp));
   endtask

   initial begin
      int c, prev;
      rst_n    = 1'b0;
      req      = '0;
      req_code = '0;
      req_8580 = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack",  int'(ack), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_id",   int'(dout_id), 0);
      rst_n = 1'b1;

      // 6581 code 0x001: 0x0008 + 0x0021 = 0x0029 -> 0x002
      convert(0, 12'h001, 1'b0, 12'h002, 1'b0);

      // Reset mid-ACCUM discards the conversion
      wait_idle();
      req_code[11:0] = 12'h001;
      req[0]         = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_ack",  int'(ack), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_dout", int'(dout), 0);
      chk("midrst_id",   int'(dout_id), 0);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (16) @(negedge clk);

      // All requesters held high from rr_ptr = 0: 0,1,2,3,0,1 every 14 cycles
      req_code = {12'h4D4, 12'h3C3, 12'h2B2, 12'h1A1};
      req_8580 = 4'hF;
      sb_q.push_back('{0, 'h1A1});
      sb_q.push_back('{1, 'h2B2});
      sb_q.push_back('{2, 'h3C3});
      sb_q.push_back('{3, 'h4D4});
      sb_q.push_back('{0, 'h1A1});
      sb_q.push_back('{1, 'h2B2});
      wait_idle();
      req  = 4'hF;
      prev = -1;
      for (int a = 0; a < 6; a++) begin
         wait_ack(c);
         if (a > 0) chk("rr_spacing", c - prev, 14);
         prev = c;
      end
      req      = '0;
      req_8580 = '0;

      // rr_ptr now 2
      convert(2, 12'h002, 1'b0, 12'h003, 1'b0);
      // rr_ptr = 3, req[2] alone: wraparound grant; full-scale 6581
      convert(2, 12'hFFF, 1'b0, 12'hFFF, 1'b0);

      // req[1] and req[3] together with rr_ptr = 3 -> 3 then 1
      wait_idle();
      req_code[12*1 +: 12] = 12'h111;
      req_code[12*3 +: 12] = 12'h333;
      req_8580[1] = 1'b1;
      req_8580[3] = 1'b1;
      sb_q.push_back('{3, 'h333});
      sb_q.push_back('{1, 'h111});
      req[1] = 1'b1;
      req[3] = 1'b1;
      wait_ack(c);
      chk("pair_first_ack3", int'(ack[3]), 1);
      req[3] = 1'b0;
      prev = c;
      wait_ack(c);
      chk("pair_spacing", c - prev, 14);
      req[1]   = 1'b0;
      req_8580 = '0;

      // 6581 0x800 -> 0x7BF, inputs disturbed during ACCUM
      convert(0, 12'h800, 1'b0, 12'h7BF, 1'b1);
      req_8580 = '0;
      // 8580 ideal
      convert(3, 12'hABC, 1'b1, 12'hABC, 1'b0);
      req_8580 = '0;

      // Single requester holding req: re-granted, acks 14 cycles apart
      wait_idle();
      req_code[12*1 +: 12] = 12'h001;
      req_8580[1] = 1'b1;
      sb_q.push_back('{1, 'h001});
      sb_q.push_back('{1, 'h001});
      sb_q.push_back('{1, 'h001});
      req[1] = 1'b1;
      prev = -1;
      for (int a = 0; a < 3; a++) begin
         wait_ack(c);
         if (a > 0) chk("regrant_spacing", c - prev, 14);
         prev = c;
      end
      req[1] = 1'b0;

      repeat (20) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/sid_dac_sched.md
# sid_dac_sched

Time-multiplexed R-2R DAC conversion engine for the SID voice/filter datapath. Up to NREQ requesters (voice waveform channels, external-filter taps) share one bit-serial weighted-sum accumulator, which evaluates one DAC bit per clock. Arbitration is round-robin. Per grant, the engine applies either the MOS 6581 non-linear bit-weight table or the ideal MOS 8580 weights. It replaces per-channel combinational 12-bit DAC adder trees with a single shared adder.

## Interface
- NREQ, 4, number of requesters (2..8); ID width IDW = max(1, clog2(NREQ)).
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester level request; held until its ack.
- req_code  in  NREQ*12  requester k's 12-bit DAC input code at bits [12k+11:12k].
- req_8580  in  NREQ  per-requester model select: 1 = 8580 ideal weights, 0 = 6581 table.
- ack  out  NREQ  one-hot, registered, 1-cycle pulse marking result delivery for that requester.
- dout  out  12  converted value, valid while ack is high; holds until the next delivery.
- dout_id  out  IDW  requester index of the current dout.
- busy  out  1  high in ACCUM and DONE.

## Operation
- Weights (16-bit, 4 fractional scale bits), bit 0 to bit 11:
  - 6581: 0x021, 0x030, 0x055, 0x0A0, 0x135, 0x256, 0x486, 0x8C6, 0x1102, 0x20F8, 0x3FEC, 0x7BED.
  - 8580: 0x10 << i.
- Accumulator: 16-bit, preset to 0x0008 (0.5 LSB rounding). Adds weight[i] when code bit i is set.
- Result: dout = acc[15:4] (truncation). Worst-case sum is 0xFFF8 for both models, so there is no overflow and no saturation logic.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE with any req high: grant the first requester at or after rr_ptr, scanning upward and wrapping modulo NREQ.
    - Capture code, 8580 select and id into internal registers.
    - Set acc = 0x0008 and bit_idx = 0, then go to ACCUM.
    - Set rr_ptr = (granted id + 1) mod NREQ.
  - IDLE with no req: stay.
  - ACCUM: add the selected weight for captured bit bit_idx and increment bit_idx. After bit_idx = 11 is processed, go to DONE.
  - DONE: ack[id] = 1, dout and dout_id update. Next state is IDLE unconditionally.
- Captured code and model are frozen during conversion. Changes on req_code or req_8580 after the grant cycle do not affect the result.
- A requester that still has req high in the IDLE cycle after its ack is treated as a new request. It is arbitrated normally, with no priority.
- A req dropped while not yet granted is not remembered. If the granted requester drops req mid-conversion, the conversion still completes and ack is still pulsed.
- Reset (asynchronous, any state, including mid-conversion):
  - State goes to IDLE; acc, bit_idx, rr_ptr, captured regs, dout and dout_id go to 0.
  - ack = 0 and busy = 0. The in-flight conversion is discarded with no ack.

## Timing
- Cycle G: IDLE with req sampled high; the grant registers at the end of G.
- Cycles G+1 .. G+12: ACCUM, one bit per cycle.
- Cycle G+13: DONE. ack, dout and dout_id are valid for exactly this cycle; dout remains stable afterward.
- Cycle G+14: IDLE, where the earliest next grant occurs.
- Throughput is one conversion per 14 cycles. All outputs are registered; there is no combinational path from req to ack.

## Test plan
- Reset, then req[0]=1, code 0x001, 6581 -> ack[0] at cycle G+13, dout = 0x002 (0x0029>>4). Assert rst_n low mid-ACCUM: ack stays 0, busy = 0, dout = 0x000.
- 6581 codes 0x002 -> 0x003, 0x800 -> 0x7BF, 0xFFF -> 0xFFF. 8580 codes 0xABC -> 0xABC and 0x001 -> 0x001.
- All four req held high continuously -> acks in order 0,1,2,3,0,... spaced 14 cycles apart, each with the correct dout_id.
- Granted requester changes req_code and req_8580 during ACCUM -> dout matches the code and model captured at grant.
- req[2] asserted alone while rr_ptr = 3 -> wraparound grant to 2. Then req[1] and req[3] both high -> 3 granted first (rr_ptr = 3), then 1.
- Single requester keeps req high after its ack -> re-granted in the next IDLE cycle, with ack pulses 14 cycles apart and never two consecutive ack cycles.
